// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Multi-channel conditioner for raw board push-buttons and switches.
//   Each channel is synchronised, debounced and edge-detected. A held button
//   also produces an auto-repeat (typematic) train of press pulses.
//
// Parameters
//   N             number of independent channels
//   DEBOUNCE      consecutive differing cycles needed to flip the level (>=1)
//   REPEAT_DELAY  cycles from the rise press to the first repeat press
//                 (0 disables auto-repeat, press then equals rise)
//   REPEAT_RATE   cycles between subsequent repeat presses (>=1)
//
// Ports
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   bt_in   raw asynchronous button inputs, active-high
//   level   debounced stable level per channel
//   rise    one-cycle pulse when level goes 0->1
//   fall    one-cycle pulse when level goes 1->0
//   press   one-cycle pulse on rise and on every auto-repeat event
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int N            = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] bt_in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press
);

  localparam int DW      = $clog2(DEBOUNCE + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam bit            REPEAT_EN  = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [DW-1:0] db_cnt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          press_q;
    logic          flip;
    rep_state_t    state;
    rep_state_t    state_next;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_next;
    logic          press_next;

    // The level flips on the DEBOUNCE-th consecutive cycle that the
    // synchronised input disagrees with it.
    assign flip = (s2 != level_q) && (db_cnt == DB_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= bt_in[ch];
        s2 <= s1;
      end
    end

    // Debounce counter, stable level and registered edge pulses. Any cycle
    // where the input agrees with the level restarts the count, so short
    // glitches never reach the level.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= flip & s2;
        fall_q <= flip & ~s2;
        if (s2 == level_q || flip) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
        if (flip) begin
          level_q <= s2;
        end
      end
    end

    // Auto-repeat state register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        rep_cnt <= '0;
        press_q <= 1'b0;
      end else begin
        state   <= state_next;
        rep_cnt <= rep_cnt_next;
        press_q <= press_next;
      end
    end

    // Auto-repeat next-state logic. A falling level is checked before the
    // terminal counts so a release never emits a stray press.
    always_comb begin
      state_next   = state;
      rep_cnt_next = rep_cnt;
      press_next   = 1'b0;
      case (state)
        IDLE: begin
          if (flip && s2) begin
            press_next = 1'b1;
            if (REPEAT_EN) begin
              state_next   = DELAY;
              rep_cnt_next = '0;
            end
          end
        end
        DELAY: begin
          if (flip && !s2) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
          end else if (rep_cnt == DELAY_LAST) begin
            press_next   = 1'b1;
            state_next   = REPEAT;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (flip && !s2) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
          end else if (rep_cnt == RATE_LAST) begin
            press_next   = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + RW'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end

    assign level[ch] = level_q;
    assign rise[ch]  = rise_q;
    assign fall[ch]  = fall_q;
    assign press[ch] = press_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Drives two conditioner instances (auto-repeat enabled and disabled) from
//   the same inputs and compares them against a behavioural model that works
//   from the history of sampled inputs and the time since each rise.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N            = 4;
  localparam int DEBOUNCE     = 4;
  localparam int REPEAT_DELAY = 10;
  localparam int REPEAT_RATE  = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] bt_in = '0;
  logic [N-1:0] level_a, rise_a, fall_a, press_a;
  logic [N-1:0] level_z, rise_z, fall_z, press_z;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N(N), .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut_a (
    .clk(clk), .reset(reset), .bt_in(bt_in),
    .level(level_a), .rise(rise_a), .fall(fall_a), .press(press_a)
  );

  button_conditioner #(
    .N(N), .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(0), .REPEAT_RATE(REPEAT_RATE)
  ) dut_z (
    .clk(clk), .reset(reset), .bt_in(bt_in),
    .level(level_z), .rise(rise_z), .fall(fall_z), .press(press_z)
  );

  // Reference model: a pin value reaches the debouncer two edges after it
  // is sampled, and the level flips once the last DEBOUNCE such values all
  // disagree with it. Presses are derived from the time since the rise.
  logic [N-1:0] m_level   = '0;
  logic [N-1:0] m_rise    = '0;
  logic [N-1:0] m_fall    = '0;
  logic [N-1:0] m_press   = '0;
  logic [N-1:0] m_press_z = '0;
  bit           hist [N][DEBOUNCE+1];
  int           since [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k <= DEBOUNCE; k++) hist[c][k] = 1'b0;
        since[c] = 0;
      end
      m_level = '0; m_rise = '0; m_fall = '0; m_press = '0; m_press_z = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        bit settle;
        settle = 1'b1;
        for (int k = 1; k <= DEBOUNCE; k++) if (hist[c][k] == m_level[c]) settle = 1'b0;
        m_rise[c] = settle && !m_level[c];
        m_fall[c] = settle && m_level[c];
        if (settle) m_level[c] = !m_level[c];
        if (m_rise[c]) since[c] = 0;
        else if (m_level[c]) since[c]++;
        m_press[c] = m_level[c] && (m_rise[c] ||
                     (since[c] >= REPEAT_DELAY && (since[c] - REPEAT_DELAY) % REPEAT_RATE == 0));
        m_press_z[c] = m_rise[c];
        for (int k = DEBOUNCE; k >= 1; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = bt_in[c];
      end
    end
  end

  logic [8*N-1:0] obs, expv;
  assign obs  = {level_a, rise_a, fall_a, press_a, level_z, rise_z, fall_z, press_z};
  assign expv = {m_level, m_rise, m_fall, m_press, m_level, m_rise, m_fall, m_press_z};

  // Reset with all buttons held, then release and watch all channels rise.
  task automatic test_reset();
    reset = 1'b0;
    bt_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({level_a, rise_a, fall_a, press_a} !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold cycle %0d: got %h, want 0000", i, {level_a, rise_a, fall_a, press_a});
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      tests_run++;
      if (level_a !== ((e >= 6) ? 4'hF : 4'h0) || rise_a !== ((e == 6) ? 4'hF : 4'h0)) begin
        tests_failed++;
        $display("[TB] FAIL reset_release edge %0d: got level %h rise %h, want level %h rise %h",
                 e, level_a, rise_a, (e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0);
      end
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL reset_model edge %0d: got %h, want %h", e, obs, expv);
      end
    end
    bt_in = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL reset_settle cycle %0d: got %h, want %h", i, obs, expv);
      end
    end
  endtask

  // A three-cycle pulse on ch0 must be rejected completely.
  task automatic test_glitch();
    int seen = 0;
    for (int i = 0; i < 14; i++) begin
      bt_in[0] = (i < 3);
      @(negedge clk);
      if (level_a[0] || rise_a[0] || press_a[0] || level_z[0]) seen++;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL glitch_model cycle %0d: got %h, want %h", i, obs, expv);
      end
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_reject: got %0d active cycles, want 0", seen);
    end
  endtask

  // ch1 bounces then settles high; exactly one rise and later one fall.
  task automatic test_bounce();
    int rise_at = -1, rises = 0, fall_at = -1, falls = 0;
    for (int i = 0; i < 4; i++) begin
      bt_in[1] = (i % 2 == 0);
      @(negedge clk);
      if (rise_a[1]) rises++;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL bounce_model cycle %0d: got %h, want %h", i, obs, expv);
      end
    end
    bt_in[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rise_a[1]) begin rises++; rise_at = k; end
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL bounce_hold_model edge %0d: got %h, want %h", k, obs, expv);
      end
    end
    tests_run++;
    if (rises !== 1 || rise_at !== DEBOUNCE + 2) begin
      tests_failed++;
      $display("[TB] FAIL bounce_rise: got %0d pulses at edge %0d, want 1 at edge %0d", rises, rise_at, DEBOUNCE + 2);
    end
    bt_in[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (fall_a[1]) begin falls++; fall_at = k; end
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL bounce_release_model edge %0d: got %h, want %h", k, obs, expv);
      end
    end
    tests_run++;
    if (falls !== 1 || fall_at !== DEBOUNCE + 2) begin
      tests_failed++;
      $display("[TB] FAIL bounce_fall: got %0d pulses at edge %0d, want 1 at edge %0d", falls, fall_at, DEBOUNCE + 2);
    end
  endtask

  // Hold ch2: presses at 0, 10, 13, ... 28; none once the level falls.
  task automatic test_auto_repeat();
    bit got_rise = 0;
    int presses = 0, late_press = 0, falls = 0;
    bt_in[2] = 1'b1;
    for (int i = 0; i < 20 && !got_rise; i++) begin
      @(negedge clk);
      got_rise = rise_a[2];
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL repeat_wait_model cycle %0d: got %h, want %h", i, obs, expv);
      end
    end
    tests_run++;
    if (!got_rise) begin
      tests_failed++;
      $display("[TB] FAIL repeat_rise_timeout: got no rise in 20 cycles, want one");
    end
    if (press_a[2]) presses++;
    for (int t = 1; t <= 30; t++) begin
      bit want;
      @(negedge clk);
      want = (t >= REPEAT_DELAY) && ((t - REPEAT_DELAY) % REPEAT_RATE == 0);
      if (press_a[2]) presses++;
      tests_run++;
      if (press_a[2] !== want) begin
        tests_failed++;
        $display("[TB] FAIL repeat_press t=%0d: got %b, want %b", t, press_a[2], want);
      end
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL repeat_model t=%0d: got %h, want %h", t, obs, expv);
      end
    end
    tests_run++;
    if (presses !== 8) begin
      tests_failed++;
      $display("[TB] FAIL repeat_count: got %0d presses, want 8", presses);
    end
    bt_in[2] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (falls > 0 && press_a[2]) late_press++;
      if (fall_a[2]) falls++;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL repeat_release_model edge %0d: got %h, want %h", k, obs, expv);
      end
    end
    tests_run++;
    if (falls !== 1 || late_press !== 0) begin
      tests_failed++;
      $display("[TB] FAIL repeat_release: got %0d falls %0d late presses, want 1 and 0", falls, late_press);
    end
  endtask

  // ch3 level falls on the same edge as the t=16 repeat terminal count.
  task automatic test_fall_priority();
    bit got_rise = 0;
    int stray = 0;
    bt_in[3] = 1'b1;
    for (int i = 0; i < 20 && !got_rise; i++) begin
      @(negedge clk);
      got_rise = rise_a[3];
    end
    tests_run++;
    if (!got_rise) begin
      tests_failed++;
      $display("[TB] FAIL prio_rise_timeout: got no rise in 20 cycles, want one");
    end
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (t == 10) bt_in[3] = 1'b0;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL prio_model t=%0d: got %h, want %h", t, obs, expv);
      end
    end
    tests_run++;
    if (fall_a[3] !== 1'b1 || press_a[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_edge: got fall %b press %b, want fall 1 press 0", fall_a[3], press_a[3]);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (press_a[3]) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("[TB] FAIL prio_idle: got %0d presses after release, want 0", stray);
    end
    // A fresh hold must restart the repeat sequence from the beginning.
    bt_in[3] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL prio_rehold_model cycle %0d: got %h, want %h", k, obs, expv);
      end
    end
    bt_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
  endtask

  // With auto-repeat disabled, a long hold gives one press with the rise.
  task automatic test_repeat_delay_zero();
    int presses = 0, misaligned = 0;
    bt_in[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (press_z[0]) presses++;
      if (press_z[0] !== rise_z[0]) misaligned++;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL rd0_model cycle %0d: got %h, want %h", k, obs, expv);
      end
    end
    tests_run++;
    if (presses !== 1 || misaligned !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rd0_press: got %0d presses %0d misaligned, want 1 and 0", presses, misaligned);
    end
    bt_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
  endtask

  // Random hold lengths on every channel, with a reset pulse mid-run.
  task automatic test_random();
    int hold [N];
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 12);
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bt_in[c] = ~bt_in[c];
          hold[c]  = $urandom_range(1, 12);
        end
      end
      if (i == 400) reset = 1'b0;
      if (i == 403) reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL random_model cycle %0d: got %h, want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_auto_repeat();
    test_fall_priority();
    test_repeat_delay_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, want finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
